// File: rtl/pm_pkg.sv
// Shared types and constants for the program-memory responder.
// Holds the load/serve FSM state type, the NOP word and default memory geometry.
package pm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } pm_state_t;

  localparam logic [31:0] PM_NOP = 32'h0;

  localparam int PM_DEPTH_DEF = 256;
  localparam int PM_AW_DEF    = 8;

endpackage

// File: rtl/pm_ram.sv
// Single-port synchronous program RAM, one write port and a registered read.
// Contents are deliberately left uninitialised; only a load defines them.
module pm_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/pm_resp.sv
// Program-memory responder: loads an instruction image from a streaming loader,
// then serves sequencer fetches with one cycle of latency.
module pm_resp
  import pm_pkg::*;
#(
  parameter int PM_DEPTH = PM_DEPTH_DEF,
  parameter int PM_AW    = PM_AW_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps_pm_cslt,
  input  logic        ps_pm_wrb,
  input  logic [15:0] ps_pm_add,
  output logic [31:0] pm_ps_op,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        pm_ps_rdy,
  output logic [15:0] pm_ld_cnt,
  output logic        pm_ld_err,
  output logic        pm_acc_err
);

  localparam logic [16:0]     DEPTH_EXT = 17'(PM_DEPTH);
  localparam logic [PM_AW-1:0] LAST_IDX = PM_AW'(PM_DEPTH - 1);

  pm_state_t   state;
  logic        fetch_ok;
  logic        in_range;
  logic        accept;
  logic        at_end;
  logic        ram_we;
  logic [PM_AW-1:0] ram_addr;
  logic [31:0] ram_rdata;

  assign in_range = ({1'b0, ps_pm_add} < DEPTH_EXT);
  assign accept   = ld_ready && ld_valid;
  assign at_end   = (pm_ld_cnt[PM_AW-1:0] == LAST_IDX);

  // Writes only happen in LOAD and legal reads only in RUN, so one port suffices.
  assign ram_we   = accept;
  assign ram_addr = ld_ready ? pm_ld_cnt[PM_AW-1:0] : ps_pm_add[PM_AW-1:0];

  pm_ram #(
    .DEPTH (PM_DEPTH),
    .AW    (PM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ld_data),
    .rdata (ram_rdata)
  );

  // The RAM read register is not reset, so the NOP gate comes from fetch_ok.
  assign pm_ps_op = fetch_ok ? ram_rdata : PM_NOP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ld_ready   <= 1'b0;
      pm_ps_rdy  <= 1'b0;
      pm_ld_cnt  <= 16'd0;
      pm_ld_err  <= 1'b0;
      pm_acc_err <= 1'b0;
      fetch_ok   <= 1'b0;
    end else begin
      fetch_ok   <= ps_pm_cslt && !ps_pm_wrb && in_range && (state == RUN);
      pm_acc_err <= ps_pm_cslt && (ps_pm_wrb || !in_range || (state != RUN));
      case (state)
        IDLE: begin
          if (ld_start) begin
            state     <= LOAD;
            ld_ready  <= 1'b1;
            pm_ld_cnt <= 16'd0;
            pm_ld_err <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            pm_ld_cnt <= pm_ld_cnt + 16'd1;
            // A full image without ld_last is an overflow: keep it but flag it.
            if (ld_last || at_end) begin
              state     <= RUN;
              ld_ready  <= 1'b0;
              pm_ps_rdy <= 1'b1;
              pm_ld_err <= !ld_last;
            end
          end
        end
        RUN: begin
          if (ld_start) begin
            state     <= LOAD;
            ld_ready  <= 1'b1;
            pm_ps_rdy <= 1'b0;
            pm_ld_cnt <= 16'd0;
            pm_ld_err <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          ld_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
